// File: rtl/dqpsk_pkg.sv
// dqpsk_pkg
// Types and helpers shared by the DQPSK mapper, its constellation LUT and any
// receiver-side slicer model.
//   phase_t      : 2-bit phase index, units of 90 degrees (0..3)
//   pair_t       : dibit pair-alignment state (which serial bit comes next)
//   sign_t       : per-axis sign of a constellation point (1 = negative)
//   gray_to_inc  : Gray-coded dibit -> phase increment
//   phase_sign   : phase index -> {i_neg, q_neg}
package dqpsk_pkg;

  localparam int PHASE_W = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic {
    PAIR_FIRST  = 1'b0,  // next en bit opens a new pair
    PAIR_SECOND = 1'b1   // next en bit completes the pair
  } pair_t;

  typedef struct packed {
    logic i_neg;
    logic q_neg;
  } sign_t;

  // Gray order keeps adjacent phases one bit apart: 00,01,11,10 -> 0,1,2,3.
  function automatic phase_t gray_to_inc(input logic [1:0] dibit);
    phase_t inc;
    case (dibit)
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      default: inc = 2'd3;
    endcase
    return inc;
  endfunction

  // Phase 0 sits in the first quadrant; each step rotates +90 degrees.
  function automatic sign_t phase_sign(input phase_t phase);
    sign_t s;
    case (phase)
      2'd0:    s = '{i_neg: 1'b0, q_neg: 1'b0};
      2'd1:    s = '{i_neg: 1'b1, q_neg: 1'b0};
      2'd2:    s = '{i_neg: 1'b1, q_neg: 1'b1};
      default: s = '{i_neg: 1'b0, q_neg: 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dqpsk_lut.sv
// dqpsk_lut
// Purely combinational constellation lookup: phase index -> signed I/Q point
// with magnitude AMP on each axis.
//   phase : phase index 0..3
//   i_val : signed in-phase amplitude, AMP_W bits
//   q_val : signed quadrature amplitude, AMP_W bits
module dqpsk_lut
  import dqpsk_pkg::*;
#(
  parameter int AMP_W = 8,
  parameter int AMP   = 90
) (
  input  phase_t                  phase,
  output logic signed [AMP_W-1:0] i_val,
  output logic signed [AMP_W-1:0] q_val
);

  localparam logic signed [AMP_W-1:0] AMP_POS = AMP_W'(AMP);
  localparam logic signed [AMP_W-1:0] AMP_NEG = -AMP_POS;

  sign_t                  sgn;
  logic [1:0]             neg;
  logic signed [AMP_W-1:0] axis [2];

  assign sgn = phase_sign(phase);
  // axis[0] is Q, axis[1] is I, matching the packed order of sign_t.
  assign neg = {sgn.i_neg, sgn.q_neg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign axis[gi] = neg[gi] ? AMP_NEG : AMP_POS;
  end

  assign i_val = axis[1];
  assign q_val = axis[0];

endmodule

// File: rtl/dqpsk_mapper.sv
// dqpsk_mapper
// Consumes the SPC's 2-bit output on the shared bit strobe, keeps track of
// pair alignment so only complete dibits are used, Gray-decodes each dibit
// to a phase increment, optionally accumulates it (DQPSK) and registers the
// resulting constellation point with a one-cycle valid pulse.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   en        : bit strobe, one new serial bit per en cycle
//   dibit_in  : SPC output, [1] = earlier bit, [0] = current bit
//   sym_start : restart pair alignment; current en bit is a first bit
//   i_out     : signed in-phase sample, held between symbols
//   q_out     : signed quadrature sample, held between symbols
//   sym_valid : one-cycle pulse when i_out/q_out update
//   phase_out : accumulated phase index (0..3)
//   sym_count : symbols emitted, wraps modulo 2^CNT_W
module dqpsk_mapper
  import dqpsk_pkg::*;
#(
  parameter int AMP_W = 8,
  parameter int AMP   = 90,
  parameter int DIFF  = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [1:0]              dibit_in,
  input  logic                    sym_start,
  output logic signed [AMP_W-1:0] i_out,
  output logic signed [AMP_W-1:0] q_out,
  output logic                    sym_valid,
  output logic [1:0]              phase_out,
  output logic [CNT_W-1:0]        sym_count
);

  pair_t                   pair_phase_reg;
  phase_t                  phase_reg;
  logic signed [AMP_W-1:0] i_reg;
  logic signed [AMP_W-1:0] q_reg;
  logic                    sym_valid_reg;
  logic [CNT_W-1:0]        sym_count_reg;

  phase_t                  inc;
  phase_t                  phase_next;
  logic signed [AMP_W-1:0] i_next;
  logic signed [AMP_W-1:0] q_next;

  always_comb begin
    inc = gray_to_inc(dibit_in);
    // The 2-bit sum wraps naturally, so 3+1 lands on 0.
    if (DIFF != 0) begin
      phase_next = phase_reg + inc;
    end else begin
      phase_next = inc;
    end
  end

  // The point for the phase being captured is looked up combinationally so
  // that phase_out and i_out/q_out load on the same edge.
  dqpsk_lut #(
    .AMP_W (AMP_W),
    .AMP   (AMP)
  ) u_lut (
    .phase (phase_next),
    .i_val (i_next),
    .q_val (q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_phase_reg <= PAIR_FIRST;
      phase_reg      <= '0;
      i_reg          <= '0;
      q_reg          <= '0;
      sym_valid_reg  <= 1'b0;
      sym_count_reg  <= '0;
    end else begin
      sym_valid_reg <= 1'b0;
      if (sym_start) begin
        // Realignment wins over a capture; with en the strobed bit is
        // already the first of the new pair.
        phase_reg      <= '0;
        pair_phase_reg <= en ? PAIR_SECOND : PAIR_FIRST;
      end else if (en) begin
        case (pair_phase_reg)
          PAIR_FIRST: begin
            pair_phase_reg <= PAIR_SECOND;
          end
          default: begin
            pair_phase_reg <= PAIR_FIRST;
            phase_reg      <= phase_next;
            i_reg          <= i_next;
            q_reg          <= q_next;
            sym_count_reg  <= sym_count_reg + CNT_W'(1);
            sym_valid_reg  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign i_out     = i_reg;
  assign q_out     = q_reg;
  assign sym_valid = sym_valid_reg;
  assign phase_out = phase_reg;
  assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_dqpsk_mapper.sv
// tb_dqpsk_mapper
// Drives an absolute (DIFF=0) and a differential (DIFF=1) mapper from the
// same emulated SPC bit stream. A bench-side model pushes the expected
// symbol of each instance at every completing bit; a negedge monitor pops
// and compares whenever sym_valid is seen, including the arrival cycle.
module tb_dqpsk_mapper;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [1:0]        dibit_in;
  logic              sym_start;

  logic signed [7:0] i_abs, q_abs, i_dif, q_dif;
  logic              v_abs, v_dif;
  logic [1:0]        ph_abs, ph_dif;
  logic [7:0]        cnt_abs, cnt_dif;

  always #5 clk = ~clk;

  dqpsk_mapper #(.AMP_W(8), .AMP(90), .DIFF(0), .CNT_W(8)) dut_abs (
    .clk(clk), .reset(reset), .en(en), .dibit_in(dibit_in), .sym_start(sym_start),
    .i_out(i_abs), .q_out(q_abs), .sym_valid(v_abs), .phase_out(ph_abs), .sym_count(cnt_abs)
  );

  dqpsk_mapper #(.AMP_W(8), .AMP(90), .DIFF(1), .CNT_W(8)) dut_dif (
    .clk(clk), .reset(reset), .en(en), .dibit_in(dibit_in), .sym_start(sym_start),
    .i_out(i_dif), .q_out(q_dif), .sym_valid(v_dif), .phase_out(ph_dif), .sym_count(cnt_dif)
  );

  typedef struct {
    int        i;
    int        q;
    int        ph;
    int        cnt;
    int        cyc;
  } exp_t;

  exp_t q_exp_abs[$];
  exp_t q_exp_dif[$];
  exp_t ea, ed;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // bench model state
  logic       m_pair;
  logic [1:0] m_acc;
  logic [7:0] m_cnt;
  logic       prev_bit;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] m_gray(input logic [1:0] d);
    case (d)
      2'b00: return 2'd0;
      2'b01: return 2'd1;
      2'b11: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic int m_i(input logic [1:0] p);
    return (p == 2'd1 || p == 2'd2) ? -90 : 90;
  endfunction

  function automatic int m_q(input logic [1:0] p);
    return (p >= 2'd2) ? -90 : 90;
  endfunction

  // One clock of stimulus; the model advances as the DUT will on this edge.
  task automatic step(input logic e, input logic b, input logic s);
    logic [1:0] d;
    logic [1:0] inc;
    exp_t x;
    en        = e;
    sym_start = s;
    d         = {prev_bit, b};
    if (e) dibit_in = d;
    if (s) begin
      m_acc  = 2'd0;
      m_pair = e;
    end else if (e) begin
      if (!m_pair) begin
        m_pair = 1'b1;
      end else begin
        m_pair = 1'b0;
        inc    = m_gray(d);
        m_acc  = m_acc + inc;
        m_cnt  = m_cnt + 8'd1;
        x = '{i: m_i(inc), q: m_q(inc), ph: int'(inc), cnt: int'(m_cnt), cyc: cyc + 1};
        q_exp_abs.push_back(x);
        x = '{i: m_i(m_acc), q: m_q(m_acc), ph: int'(m_acc), cnt: int'(m_cnt), cyc: cyc + 1};
        q_exp_dif.push_back(x);
      end
    end
    if (e) prev_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    sym_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      en       = 1'b1;
      dibit_in = 2'($urandom);
      @(posedge clk);
      #1;
      chk("rst_i",     int'(i_abs) | int'(q_abs) | int'(i_dif) | int'(q_dif), 0);
      chk("rst_valid", int'(v_abs) + int'(v_dif), 0);
      chk("rst_phase", int'(ph_abs) + int'(ph_dif), 0);
      chk("rst_cnt",   int'(cnt_abs) + int'(cnt_dif), 0);
    end
    chk("rst_pending", q_exp_abs.size() + q_exp_dif.size(), 0);
    q_exp_abs.delete();
    q_exp_dif.delete();
    reset    = 1'b0;
    en       = 1'b0;
    m_pair   = 1'b0;
    m_acc    = 2'd0;
    m_cnt    = 8'd0;
    prev_bit = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (v_abs) begin
      if (q_exp_abs.size() == 0) begin
        chk("abs_spurious_valid", 1, 0);
      end else begin
        ea = q_exp_abs.pop_front();
        chk("abs_i", int'(i_abs), ea.i);
        chk("abs_q", int'(q_abs), ea.q);
        chk("abs_phase", int'(ph_abs), ea.ph);
        chk("abs_cnt", int'(cnt_abs), ea.cnt);
        chk("abs_latency", cyc, ea.cyc);
        $display("sym abs: I=%0d Q=%0d ph=%0d cnt=%0d", i_abs, q_abs, ph_abs, cnt_abs);
      end
    end
    if (v_dif) begin
      if (q_exp_dif.size() == 0) begin
        chk("dif_spurious_valid", 1, 0);
      end else begin
        ed = q_exp_dif.pop_front();
        chk("dif_i", int'(i_dif), ed.i);
        chk("dif_q", int'(q_dif), ed.q);
        chk("dif_phase", int'(ph_dif), ed.ph);
        chk("dif_cnt", int'(cnt_dif), ed.cnt);
        chk("dif_latency", cyc, ed.cyc);
        $display("sym dif: I=%0d Q=%0d ph=%0d cnt=%0d", i_dif, q_dif, ph_dif, cnt_dif);
      end
    end
  end

  typedef struct {
    logic b;
    logic chk_now;
    int   ei;
    int   eq;
    int   eph;
    int   ecnt;
  } vec_t;

  vec_t av[8];
  vec_t dv[10];

  initial begin
    reset = 1'b1; en = 1'b0; dibit_in = 2'b00; sym_start = 1'b0;
    m_pair = 1'b0; m_acc = 2'd0; m_cnt = 8'd0; prev_bit = 1'b0;

    // absolute map: bits 0,0,0,1,1,1,1,0 -> dibits 00,01,11,10
    av[0] = '{1'b0, 1'b0,   0,   0, 0, 0};
    av[1] = '{1'b0, 1'b1,  90,  90, 0, 1};
    av[2] = '{1'b0, 1'b0,   0,   0, 0, 0};
    av[3] = '{1'b1, 1'b1, -90,  90, 1, 2};
    av[4] = '{1'b1, 1'b0,   0,   0, 0, 0};
    av[5] = '{1'b1, 1'b1, -90, -90, 2, 3};
    av[6] = '{1'b1, 1'b0,   0,   0, 0, 0};
    av[7] = '{1'b0, 1'b1,  90, -90, 3, 4};
    // differential wrap: five dibits 01
    dv[0] = '{1'b0, 1'b0,   0,   0, 0, 0};
    dv[1] = '{1'b1, 1'b1, -90,  90, 1, 1};
    dv[2] = '{1'b0, 1'b0,   0,   0, 0, 0};
    dv[3] = '{1'b1, 1'b1, -90, -90, 2, 2};
    dv[4] = '{1'b0, 1'b0,   0,   0, 0, 0};
    dv[5] = '{1'b1, 1'b1,  90, -90, 3, 3};
    dv[6] = '{1'b0, 1'b0,   0,   0, 0, 0};
    dv[7] = '{1'b1, 1'b1,  90,  90, 0, 4};
    dv[8] = '{1'b0, 1'b0,   0,   0, 0, 0};
    dv[9] = '{1'b1, 1'b1, -90,  90, 1, 5};

    do_reset(3);

    for (int k = 0; k < 8; k++) begin
      step(1'b1, av[k].b, 1'b0);
      if (av[k].chk_now) begin
        chk("tab_abs_valid", int'(v_abs), 1);
        chk("tab_abs_i", int'(i_abs), av[k].ei);
        chk("tab_abs_q", int'(q_abs), av[k].eq);
        chk("tab_abs_cnt", int'(cnt_abs), av[k].ecnt);
      end
    end
    step(1'b0, 1'b0, 1'b0);

    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, dv[k].b, 1'b0);
      if (dv[k].chk_now) begin
        chk("tab_dif_phase", int'(ph_dif), dv[k].eph);
        chk("tab_dif_i", int'(i_dif), dv[k].ei);
        chk("tab_dif_q", int'(q_dif), dv[k].eq);
        chk("tab_dif_cnt", int'(cnt_dif), dv[k].ecnt);
      end
    end
    step(1'b0, 1'b0, 1'b0);

    // gapped strobe, bits 1,1 one en in three
    do_reset(1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_no_early_valid", int'(v_abs), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_valid", int'(v_abs) + int'(v_dif), 2);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("gap_hold_valid", int'(v_abs) + int'(v_dif), 0);
      chk("gap_hold_i", int'(i_abs), -90);
      chk("gap_hold_q", int'(q_dif), -90);
    end

    // realign: one dibit 01 first so the restart from 0 is visible
    do_reset(1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("realign_no_sym", int'(v_abs) + int'(v_dif), 0);
    chk("realign_phase0", int'(ph_dif), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("realign_sym", int'(v_dif), 1);
    chk("realign_dif_phase", int'(ph_dif), 1);
    chk("realign_dif_i", int'(i_dif), -90);
    // sym_start without en drops a half pair
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("idle_start_no_sym", int'(v_abs), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("idle_start_sym", int'(v_abs), 1);
    chk("idle_start_i", int'(i_abs), -90);
    step(1'b0, 1'b0, 1'b0);

    // reset mid-pair, then count wrap over 256 symbols
    do_reset(1);
    step(1'b1, 1'b1, 1'b0);
    do_reset(1);
    for (int k = 1; k <= 256; k++) begin
      step(1'b1, 1'($urandom), 1'b0);
      if (k == 1) chk("midpair_discard", int'(v_abs), 0);
      step(1'b1, 1'($urandom), 1'b0);
      if (k == 255) chk("wrap_cnt_255", int'(cnt_abs), 255);
      if (k == 256) chk("wrap_cnt_0", int'(cnt_dif), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("final_pending", q_exp_abs.size() + q_exp_dif.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
